// File: rtl/seq_det_scheduler.sv
// seq_det_scheduler
//
// Front-end controller that shares one serial sequence detector between two
// byte-wide requesters. A round-robin arbiter in IDLE picks a requester. The
// controller then clears the detector for one cycle and shifts the granted
// word into it MSB-first, one bit per clock. It keeps counting rising edges
// of the detector output for a short drain window, and finally returns a
// single-cycle result tagged with the requester ID.
//
// Parameters:
//   DATA_W    - frame width in bits (>= 2)
//   DRAIN_CYC - cycles after the last data bit during which hits still count (>= 1)
//   DRAIN_X   - value driven on det_x outside SHIFT
//   CW        - width of the hit counter / rsp_hits
//
// Ports:
//   clk, rst               - clock (rising edge), asynchronous active-high reset
//   req0_valid/data/ready  - requester 0 handshake (ready is combinational)
//   req1_valid/data/ready  - requester 1 handshake (ready is combinational)
//   det_clr                - one-cycle clear pulse to the detector
//   det_x                  - serial bit to the detector
//   det_z                  - detector output
//   rsp_valid              - one-cycle result strobe
//   rsp_id                 - requester the result belongs to
//   rsp_hits               - rising edges of det_z seen in the frame window
//   busy                   - high whenever the controller is not idle

module seq_det_scheduler #(
    parameter int   DATA_W    = 8,
    parameter int   DRAIN_CYC = 3,
    parameter logic DRAIN_X   = 1'b0,
    parameter int   CW        = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              det_clr,
    output logic              det_x,
    input  logic              det_z,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [CW-1:0]     rsp_hits,
    output logic              busy
);

    localparam int BW = $clog2(DATA_W);
    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        SHIFT,
        DRAIN,
        DONE
    } state_t;

    state_t            state_q;
    logic [DATA_W-1:0] shreg_q;
    logic [BW-1:0]     bit_cnt_q;
    logic [DW-1:0]     drain_cnt_q;
    logic [CW-1:0]     hits_q;
    logic [CW-1:0]     hits_d;
    logic              z_prev_q;
    logic              cur_id_q;
    logic              last_id_q;
    logic              det_clr_q;
    logic              det_x_q;
    logic              rsp_valid_q;
    logic              rsp_id_q;
    logic [CW-1:0]     rsp_hits_q;
    logic              busy_q;

    logic              grant0;
    logic              grant1;
    logic              rise;

    // On a tie the requester that was not served last wins; a lone
    // requester always wins regardless of history.
    always_comb begin
        grant0     = req0_valid & (~req1_valid | last_id_q);
        grant1     = req1_valid & (~req0_valid | ~last_id_q);
        req0_ready = (state_q == IDLE) & grant0;
        req1_ready = (state_q == IDLE) & grant1;
    end

    // Saturating rising-edge counter; the next value is also what gets
    // published on the DONE transition so the final drain sample is included.
    always_comb begin
        rise   = det_z & ~z_prev_q;
        hits_d = hits_q;
        if (rise && (hits_q != {CW{1'b1}})) begin
            hits_d = hits_q + CW'(1);
        end
    end

    // Single FSM process; every output is registered and set on the
    // transition into the state it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            drain_cnt_q <= '0;
            hits_q      <= '0;
            z_prev_q    <= 1'b0;
            cur_id_q    <= 1'b0;
            last_id_q   <= 1'b1;
            det_clr_q   <= 1'b0;
            det_x_q     <= DRAIN_X;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_hits_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req0_ready || req1_ready) begin
                        shreg_q   <= req1_ready ? req1_data : req0_data;
                        cur_id_q  <= req1_ready;
                        last_id_q <= req1_ready;
                        det_clr_q <= 1'b1;
                        det_x_q   <= DRAIN_X;
                        busy_q    <= 1'b1;
                        state_q   <= CLR;
                    end
                end
                CLR: begin
                    // The first data bit is presented as SHIFT is entered.
                    det_clr_q <= 1'b0;
                    hits_q    <= '0;
                    z_prev_q  <= 1'b0;
                    bit_cnt_q <= '0;
                    det_x_q   <= shreg_q[DATA_W-1];
                    shreg_q   <= {shreg_q[DATA_W-2:0], 1'b0};
                    state_q   <= SHIFT;
                end
                SHIFT: begin
                    hits_q   <= hits_d;
                    z_prev_q <= det_z;
                    if (bit_cnt_q == BW'(DATA_W - 1)) begin
                        drain_cnt_q <= DW'(DRAIN_CYC - 1);
                        det_x_q     <= DRAIN_X;
                        state_q     <= DRAIN;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + BW'(1);
                        det_x_q   <= shreg_q[DATA_W-1];
                        shreg_q   <= {shreg_q[DATA_W-2:0], 1'b0};
                    end
                end
                DRAIN: begin
                    hits_q   <= hits_d;
                    z_prev_q <= det_z;
                    if (drain_cnt_q == '0) begin
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= cur_id_q;
                        rsp_hits_q  <= hits_d;
                        state_q     <= DONE;
                    end else begin
                        drain_cnt_q <= drain_cnt_q - DW'(1);
                    end
                end
                DONE: begin
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: begin
                    det_clr_q   <= 1'b0;
                    det_x_q     <= DRAIN_X;
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign det_clr   = det_clr_q;
    assign det_x     = det_x_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_hits  = rsp_hits_q;
    assign busy      = busy_q;

endmodule
